// File: rtl/bounce_emulator.sv
// Bouncy-switch emulator: every CLEAN_IN level change makes RAW_OUT chatter for BOUNCE_CYCLES, then settle.
// Latency: 2-flop sync + 1 detect edge; RAW_OUT == level BOUNCE_CYCLES edges after the last detect.
// No backpressure. Define BOUNCE_ONE_SIDED_EN to bounce rising changes only.
module bounce_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 1000000,
    parameter int unsigned MIN_HOLD      = 16,
    parameter int unsigned MAX_HOLD_LOG2 = 12,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLEAN_IN,
    output logic       RAW_OUT,
    output logic       BUSY,
    output logic [7:0] TOGGLES
);
    localparam int unsigned WIN_W  = $clog2(BOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(MIN_HOLD + (1 << MAX_HOLD_LOG2));
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [WIN_W-1:0]  WIN_LOAD = WIN_W'(BOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MIN = HOLD_W'(MIN_HOLD);

    typedef enum logic {IDLE, BOUNCE} state_t;

    state_t            state_q, state_d;
    logic              sync_meta_q, sync_q;
    logic              level_q, level_d;
    logic              raw_q, raw_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_load;
    logic [7:0]        tog_q, tog_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              change, enter;

    assign change = (sync_q != level_q);
`ifdef BOUNCE_ONE_SIDED_EN
    assign enter  = change & sync_q;
`else
    assign enter  = change;
`endif

    // Reload with interval-1 so the next toggle lands exactly `interval` edges later.
    assign hold_load = HOLD_MIN + HOLD_W'(lfsr_q[MAX_HOLD_LOG2-1:0]) - HOLD_W'(1);
    assign lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            level_q     <= 1'b0;
            raw_q       <= 1'b0;
            win_q       <= '0;
            hold_q      <= '0;
            tog_q       <= 8'd0;
            lfsr_q      <= SEED_EFF;
        end else begin
            state_q     <= state_d;
            sync_meta_q <= CLEAN_IN;
            sync_q      <= sync_meta_q;
            level_q     <= level_d;
            raw_q       <= raw_d;
            win_q       <= win_d;
            hold_q      <= hold_d;
            tog_q       <= tog_d;
            lfsr_q      <= lfsr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        raw_d   = raw_q;
        win_d   = win_q;
        hold_d  = hold_q;
        tog_d   = tog_q;
        case (state_q)
            IDLE: begin
                if (enter) begin
                    level_d = sync_q;
                    raw_d   = ~raw_q;
                    win_d   = WIN_LOAD;
                    hold_d  = hold_load;
                    tog_d   = 8'd1;
                    state_d = BOUNCE;
                end else if (change) begin
                    level_d = sync_q;
                    raw_d   = 1'b0;
                    tog_d   = 8'd0;
                end
            end
            BOUNCE: begin
                if (change || (win_q != '0)) begin
                    // A retrigger only restarts the window; the toggle train keeps running.
                    if (change) begin
                        level_d = sync_q;
                        win_d   = WIN_LOAD;
                    end else begin
                        win_d   = win_q - WIN_W'(1);
                    end
                    if (hold_q == '0) begin
                        raw_d  = ~raw_q;
                        hold_d = hold_load;
                        tog_d  = (tog_q == 8'hFF) ? tog_q : tog_q + 8'd1;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end else begin
                    raw_d   = level_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY    = (state_q == BOUNCE);
        RAW_OUT = raw_q;
        TOGGLES = tog_q;
    end
endmodule

// File: tb/tb_bounce_emulator.sv
// Bench for bounce_emulator: event-time reference model of toggle instants, window end and TOGGLES,
// plus direct timing checks. Instances: a (64,2,2,ACE1), b (seed 0 modelled as seed 1), c (4000,1,1).
module tb_bounce_emulator;
    logic       clk;
    logic       rst_a, cin_a, rst_c, cin_c;
    logic       raw_a, busy_a, raw_b, busy_b, raw_c, busy_c;
    logic [7:0] tog_a, tog_b, tog_c;

    int errors = 0;
    int checks = 0;

    bounce_emulator #(.BOUNCE_CYCLES(64), .MIN_HOLD(2), .MAX_HOLD_LOG2(2), .LFSR_SEED(16'hACE1)) dut_a (
        .CLK(clk), .RST(rst_a), .CLEAN_IN(cin_a), .RAW_OUT(raw_a), .BUSY(busy_a), .TOGGLES(tog_a));
    bounce_emulator #(.BOUNCE_CYCLES(64), .MIN_HOLD(2), .MAX_HOLD_LOG2(2), .LFSR_SEED(16'h0000)) dut_b (
        .CLK(clk), .RST(rst_a), .CLEAN_IN(cin_a), .RAW_OUT(raw_b), .BUSY(busy_b), .TOGGLES(tog_b));
    bounce_emulator #(.BOUNCE_CYCLES(4000), .MIN_HOLD(1), .MAX_HOLD_LOG2(1), .LFSR_SEED(16'hACE1)) dut_c (
        .CLK(clk), .RST(rst_c), .CLEAN_IN(cin_c), .RAW_OUT(raw_c), .BUSY(busy_c), .TOGGLES(tog_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: absolute edge numbers for the next toggle and for the window end.
    int          p_b[3]    = '{64, 64, 4000};
    int          p_mh[3]   = '{2, 2, 1};
    int          p_ml[3]   = '{2, 2, 1};
    logic [15:0] p_seed[3] = '{16'hACE1, 16'h0001, 16'hACE1};
    longint      cyc = 0;
    logic        m_raw[3], m_busy[3], m_level[3], m_s1[3], m_s2[3];
    logic [7:0]  m_tog[3];
    logic [15:0] m_lfsr[3];
    longint      m_end[3], m_next[3];

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic model_step(input int i, input logic rst, input logic cin);
        logic sync;
        int   iv;
        if (rst) begin
            m_raw[i] = 0; m_busy[i] = 0; m_tog[i] = 0; m_level[i] = 0;
            m_s1[i] = 0; m_s2[i] = 0; m_lfsr[i] = p_seed[i];
            return;
        end
        sync = m_s2[i];
        iv   = p_mh[i] + (int'(m_lfsr[i]) & ((1 << p_ml[i]) - 1));
        if (!m_busy[i]) begin
            if (sync != m_level[i]) begin
                m_level[i] = sync;
`ifdef BOUNCE_ONE_SIDED_EN
                if (!sync) begin
                    m_raw[i] = 0; m_tog[i] = 0;
                end else begin
`else
                begin
`endif
                    m_busy[i] = 1; m_end[i] = cyc + p_b[i]; m_raw[i] = ~m_raw[i];
                    m_tog[i] = 1; m_next[i] = cyc + iv;
                end
            end
        end else if (sync != m_level[i] || cyc != m_end[i]) begin
            if (sync != m_level[i]) begin
                m_level[i] = sync; m_end[i] = cyc + p_b[i];
            end
            if (cyc == m_next[i]) begin
                m_raw[i] = ~m_raw[i]; m_next[i] = cyc + iv;
                if (m_tog[i] != 8'hFF) m_tog[i] = m_tog[i] + 8'd1;
            end
        end else begin
            m_busy[i] = 0; m_raw[i] = m_level[i];
        end
        m_s2[i] = m_s1[i]; m_s1[i] = cin; m_lfsr[i] = lstep(m_lfsr[i]);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step(0, rst_a, cin_a);
        model_step(1, rst_a, cin_a);
        model_step(2, rst_c, cin_c);
    end

    task automatic test_reset;
        rst_a = 1; rst_c = 1; cin_a = 0; cin_c = 0;
        repeat (3) @(negedge clk);
        rst_a = 0; rst_c = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            checks++;
            if ({raw_a, busy_a, tog_a} !== 10'd0) begin
                errors++;
                $display("FAIL reset_a j=%0d got raw=%b busy=%b tog=%0d want 0/0/0", j, raw_a, busy_a, tog_a);
            end
            checks++;
            if ({raw_b, busy_b, tog_b} !== 10'd0) begin
                errors++;
                $display("FAIL reset_b j=%0d got raw=%b busy=%b tog=%0d want 0/0/0", j, raw_b, busy_b, tog_b);
            end
        end
        checks++;
        if ({raw_c, busy_c, tog_c} !== 10'd0) begin
            errors++;
            $display("FAIL reset_c got raw=%b busy=%b tog=%0d want 0/0/0", raw_c, busy_c, tog_c);
        end
    endtask

    task automatic test_level_change(input logic lvl);
        int   busy_cnt = 0, first_busy = -1, first_tog = -1, ntog = 0, last_tog = -1;
        int   gap_bad = 0, settle_bad = 0;
        logic prev_raw;
        bit   one_sided = 0;
`ifdef BOUNCE_ONE_SIDED_EN
        one_sided = !lvl;
`endif
        prev_raw = raw_a;
        cin_a = lvl;
        for (int j = 0; j <= 80; j++) begin
            @(negedge clk);
            checks++;
            if ({raw_a, busy_a, tog_a} !== {m_raw[0], m_busy[0], m_tog[0]}) begin
                errors++;
                $display("FAIL level_model_a lvl=%b j=%0d got %b/%b/%0d want %b/%b/%0d", lvl, j,
                         raw_a, busy_a, tog_a, m_raw[0], m_busy[0], m_tog[0]);
            end
            checks++;
            if ({raw_b, busy_b, tog_b} !== {m_raw[1], m_busy[1], m_tog[1]}) begin
                errors++;
                $display("FAIL level_model_b lvl=%b j=%0d got %b/%b/%0d want %b/%b/%0d", lvl, j,
                         raw_b, busy_b, tog_b, m_raw[1], m_busy[1], m_tog[1]);
            end
            if (busy_a) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = j;
            end
            if (raw_a !== prev_raw) begin
                if (first_tog < 0) first_tog = j;
                if (busy_a) begin
                    ntog++;
                    if (last_tog >= 0 && (j - last_tog < 2 || j - last_tog > 5)) gap_bad++;
                    last_tog = j;
                end
                prev_raw = raw_a;
            end
            if (!one_sided && j >= 66 && (raw_a !== lvl || busy_a !== 1'b0)) settle_bad++;
        end
        checks++;
        if (one_sided) begin
            if (busy_cnt != 0 || first_tog != 2) begin
                errors++;
                $display("FAIL one_sided_timing busy_cnt=%0d first_change=%0d want 0 and 2", busy_cnt, first_tog);
            end
        end else if (first_busy != 2 || busy_cnt != 64 || first_tog != 2) begin
            errors++;
            $display("FAIL level_timing lvl=%b first_busy=%0d busy_cnt=%0d first_tog=%0d want 2/64/2",
                     lvl, first_busy, busy_cnt, first_tog);
        end
        checks++;
        if (gap_bad != 0 || settle_bad != 0) begin
            errors++;
            $display("FAIL level_gaps lvl=%b bad_gaps=%0d unsettled_cycles=%0d want 0/0", lvl, gap_bad, settle_bad);
        end
        checks++;
        if ({raw_a, busy_a, tog_a} !== {lvl, 1'b0, 8'(ntog)}) begin
            errors++;
            $display("FAIL level_final lvl=%b got raw=%b busy=%b tog=%0d want %b/0/%0d",
                     lvl, raw_a, busy_a, tog_a, lvl, ntog);
        end
    endtask

    task automatic test_retrigger;
        int busy_bad = 0, raw_bad = 0;
        cin_a = 1;
        for (int j = 0; j <= 100; j++) begin
            @(negedge clk);
            checks++;
            if ({raw_a, busy_a, tog_a} !== {m_raw[0], m_busy[0], m_tog[0]}) begin
                errors++;
                $display("FAIL retrig_model j=%0d got %b/%b/%0d want %b/%b/%0d", j,
                         raw_a, busy_a, tog_a, m_raw[0], m_busy[0], m_tog[0]);
            end
            if (busy_a !== (j >= 2 && j <= 85)) busy_bad++;
            if (j >= 86 && raw_a !== 1'b0) raw_bad++;
            if (j == 19) cin_a = 0;
        end
        checks++;
        if (busy_bad != 0 || raw_bad != 0) begin
            errors++;
            $display("FAIL retrig_timing busy_wrong=%0d raw_wrong=%0d want 0/0", busy_bad, raw_bad);
        end
    endtask

    task automatic test_back_to_back;
        logic lv[24];
        int   du[24];
        logic trace[$];
        int   diff = 0, idx = 0;
        for (int s = 0; s < 24; s++) begin
            lv[s] = 1'($urandom_range(0, 1));
            du[s] = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 90));
        end
        for (int run = 0; run < 2; run++) begin
            rst_a = 1;
            repeat (3) @(negedge clk);
            rst_a = 0;
            idx = 0;
            for (int s = 0; s < 24; s++) begin
                cin_a = lv[s];
                for (int t = 0; t < du[s]; t++) begin
                    @(negedge clk);
                    checks++;
                    if ({raw_a, busy_a, tog_a} !== {m_raw[0], m_busy[0], m_tog[0]}) begin
                        errors++;
                        $display("FAIL rand_model_a run=%0d cyc=%0d got %b/%b/%0d want %b/%b/%0d", run, cyc,
                                 raw_a, busy_a, tog_a, m_raw[0], m_busy[0], m_tog[0]);
                    end
                    checks++;
                    if ({raw_b, busy_b, tog_b} !== {m_raw[1], m_busy[1], m_tog[1]}) begin
                        errors++;
                        $display("FAIL rand_model_b run=%0d cyc=%0d got %b/%b/%0d want %b/%b/%0d", run, cyc,
                                 raw_b, busy_b, tog_b, m_raw[1], m_busy[1], m_tog[1]);
                    end
                    if (run == 0) trace.push_back(raw_a);
                    else if (raw_a !== trace[idx]) diff++;
                    idx++;
                end
            end
        end
        checks++;
        if (diff != 0) begin
            errors++;
            $display("FAIL repeat_trace differing_cycles=%0d want 0", diff);
        end
        cin_a = 0;
        repeat (100) @(negedge clk);
    endtask

    task automatic test_saturate;
        cin_c = 1;
        for (int j = 0; j < 4100; j++) begin
            @(negedge clk);
            checks++;
            if ({raw_c, busy_c, tog_c} !== {m_raw[2], m_busy[2], m_tog[2]}) begin
                errors++;
                $display("FAIL sat_model j=%0d got %b/%b/%0d want %b/%b/%0d", j,
                         raw_c, busy_c, tog_c, m_raw[2], m_busy[2], m_tog[2]);
            end
        end
        checks++;
        if ({raw_c, busy_c, tog_c} !== {1'b1, 1'b0, 8'd255}) begin
            errors++;
            $display("FAIL sat_final got raw=%b busy=%b tog=%0d want 1/0/255", raw_c, busy_c, tog_c);
        end
        cin_c = 0;
        repeat (100) @(negedge clk);
        checks++;
        if (busy_c !== 1'b1) begin
            errors++;
            $display("FAIL midbounce_pre got busy=%b want 1", busy_c);
        end
        rst_c = 1;
        @(negedge clk);
        rst_c = 0;
        checks++;
        if ({raw_c, busy_c, tog_c} !== 10'd0) begin
            errors++;
            $display("FAIL midbounce_rst got raw=%b busy=%b tog=%0d want 0/0/0", raw_c, busy_c, tog_c);
        end
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            checks++;
            if ({raw_c, busy_c, tog_c} !== {m_raw[2], m_busy[2], m_tog[2]}) begin
                errors++;
                $display("FAIL post_rst_model j=%0d got %b/%b/%0d want %b/%b/%0d", j,
                         raw_c, busy_c, tog_c, m_raw[2], m_busy[2], m_tog[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_level_change(1'b1);
        test_level_change(1'b0);
        test_retrigger();
        test_back_to_back();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bounce_emulator.md
Name: bounce_emulator

Overview:
Generates a mechanically bouncy switch signal from a clean level input, for board-level and simulation testing of the team's debounce logic.
- On every level change of CLEAN_IN, RAW_OUT chatters with pseudo-random pulse widths for a fixed bounce window, then settles to the new level.
- Sits between a clean source (slide switch, testbench driver, pattern generator) and any input that expects a raw pushbutton.

Parameters:
- BOUNCE_CYCLES, 1000000, length of the bounce window in CLK cycles (10 ms at 100 MHz); must be >= 1.
- MIN_HOLD, 16, minimum cycles between RAW_OUT toggles while bouncing; must be >= 1.
- MAX_HOLD_LOG2, 12, random hold component is lfsr[MAX_HOLD_LOG2-1:0]; range 1..15.
- LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is loaded as 16'h0001.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous reset, active-high.
- CLEAN_IN  input  1  clean level to emulate; asynchronous to CLK.
- RAW_OUT  output  1  emulated bouncy switch output (registered).
- BUSY  output  1  high while the bounce window is active.
- TOGGLES  output  8  count of RAW_OUT toggles in the current or last bounce event; saturates at 255.

Behaviour:
- Reset (RST high at a CLK edge): RAW_OUT=0, BUSY=0, TOGGLES=0, level=0, both synchroniser flops=0, state=IDLE, window and hold counters=0, lfsr=LFSR_SEED (or 1 if the seed is 0). Reset overrides all other activity, including mid-bounce.
- Synchroniser: CLEAN_IN passes through 2 flops to give sync. A change present before edge k is visible on sync after edge k+1.
- LFSR: 16-bit Galois, mask 16'hB400. Shifts every cycle outside reset and never reaches 0.
- interval = MIN_HOLD + lfsr[MAX_HOLD_LOG2-1:0], zero-extended. Hold counter width is wide enough for MIN_HOLD + 2^MAX_HOLD_LOG2 - 1.
- Window counter width is $clog2(BOUNCE_CYCLES+1).
- States: IDLE, BOUNCE.
- IDLE:
  - RAW_OUT == level; BUSY=0.
  - When sync != level (edge k+2): level<=sync, RAW_OUT<=~RAW_OUT, window<=BOUNCE_CYCLES-1, hold<=interval-1, TOGGLES<=1, BUSY<=1, go to BOUNCE.
- BOUNCE, evaluated each edge in this priority:
  1. sync != level (retrigger): level<=sync, window<=BOUNCE_CYCLES-1. The hold counter and toggle train continue uninterrupted. TOGGLES is not cleared.
  2. window == 0: RAW_OUT<=level, BUSY<=0, go to IDLE. This wins over a simultaneous hold expiry, so no toggle happens on that edge.
  3. Otherwise the window decrements.
     - If hold == 0: RAW_OUT<=~RAW_OUT, hold<=interval-1, TOGGLES<=TOGGLES+1 (saturating at 255).
     - Else hold decrements.
- Timing:
  - BUSY is high for exactly BOUNCE_CYCLES cycles after the last detected change.
  - RAW_OUT==level is guaranteed from edge (detect edge + BOUNCE_CYCLES) onward.
- Glitches on CLEAN_IN shorter than 1 cycle may be missed. Any change captured by sync is either processed or retriggers the window.
- TOGGLES holds its value in IDLE until the next event starts.

Optional Feature:
BOUNCE_ONE_SIDED_EN
- Defined: only rising level changes (sync 0->1) enter BOUNCE. A falling change detected in IDLE sets level=0 and RAW_OUT=0 on the same edge, leaves BUSY at 0, and sets TOGGLES to 0. A falling change detected in BOUNCE is treated as a retrigger as normal.
- Undefined: both edge directions bounce identically (default).

Test Plan:
Bench parameters unless noted: BOUNCE_CYCLES=64, MIN_HOLD=2, MAX_HOLD_LOG2=2, LFSR_SEED=16'hACE1.
1. RST high for 3 cycles with CLEAN_IN=0 -> RAW_OUT=0, BUSY=0, TOGGLES=0; all remain constant for 100 further cycles.
2. CLEAN_IN 0->1 before edge k:
   - RAW_OUT toggles after edge k+2; BUSY=1 from k+2 to k+65.
   - Gaps between toggles are 2..5 cycles.
   - RAW_OUT=1 and BUSY=0 after edge k+66 and stable thereafter.
   - TOGGLES equals the toggle count observed by the scoreboard.
3. Retrigger: CLEAN_IN 0->1, then 1->0 20 cycles later -> BUSY stays high continuously; RAW_OUT settles to 0 exactly 64 cycles after the second detect edge.
4. Falling event from settled 1: CLEAN_IN 1->0 -> same timing as scenario 2, final RAW_OUT=0. With BOUNCE_ONE_SIDED_EN defined -> RAW_OUT=0 two edges after the change, BUSY never asserts, TOGGLES=0.
5. BOUNCE_CYCLES=4000, MIN_HOLD=1, MAX_HOLD_LOG2=1 -> TOGGLES saturates at 255. Mid-bounce RST -> RAW_OUT=0, BUSY=0 on the next edge.
6. Two runs with identical stimulus and seed -> identical RAW_OUT traces. LFSR_SEED=0 -> behaves exactly as seed 16'h0001.
